// File: rtl/parity_gen_stream_if.sv
// Stream bundle for parity_gen_stream: input beat channel, output beat channel and status.
// slave is the block's view; master is the producer/consumer (test or system) view.
interface parity_gen_stream_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              in_last;
  logic              in_par;
  logic              odd_sel;
  logic              chk_en;
  logic              err_clr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_par;
  logic              out_last;
  logic              frame_par;
  logic              par_err;
  logic              frame_trunc;
  logic [CNT_W-1:0]  err_cnt;

  modport slave (
    input  in_valid, in_data, in_last, in_par, odd_sel, chk_en, err_clr, out_ready,
    output in_ready, out_valid, out_data, out_par, out_last, frame_par, par_err,
           frame_trunc, err_cnt
  );

  modport master (
    output in_valid, in_data, in_last, in_par, odd_sel, chk_en, err_clr, out_ready,
    input  in_ready, out_valid, out_data, out_par, out_last, frame_par, par_err,
           frame_trunc, err_cnt
  );
endinterface

// File: rtl/parity_gen_stream.sv
// Streaming parity generator/checker: per-beat parity, frame parity, check-mode error count.
// One registered output stage; 1-cycle latency, in_ready = !out_valid || out_ready.
module parity_gen_stream #(
  parameter int DATA_W    = 8,
  parameter int MAX_BEATS = 16,
  parameter int CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  parity_gen_stream_if.slave    s
);
  localparam int CW = $clog2(MAX_BEATS + 1);
  localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_BEATS);
  localparam logic [CNT_W-1:0] ERR_MAX = {CNT_W{1'b1}};

  typedef enum logic {IDLE, FRAME} state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     beat_cnt_q, beat_cnt_d;
  logic              acc_q, acc_d;
  logic              odd_f_q, odd_f_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_par_q, out_par_d;
  logic              out_last_q, out_last_d;
  logic              frame_par_q, frame_par_d;
  logic              par_err_q, par_err_d;
  logic              frame_trunc_q, frame_trunc_d;
  logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic          in_ready;
  logic          accept;
  logic          odd_eff;
  logic          dpar;
  logic [CW-1:0] cnt_next;
  logic          trunc;
  logic          last;
  logic          err_now;

  // Reset empties the output stage, so ready is reported high while rst_n is low.
  assign in_ready = !out_valid_q || s.out_ready || !rst_n;
  assign accept   = s.in_valid && in_ready && rst_n;

  always_comb begin
    state_d       = state_q;
    beat_cnt_d    = beat_cnt_q;
    acc_d         = acc_q;
    odd_f_d       = odd_f_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_par_d     = out_par_q;
    out_last_d    = out_last_q;
    frame_par_d   = frame_par_q;
    par_err_d     = par_err_q;
    frame_trunc_d = frame_trunc_q;
    err_cnt_d     = err_cnt_q;

    // odd_sel only takes effect on the first beat of a frame.
    odd_eff  = (state_q == IDLE) ? s.odd_sel : odd_f_q;
    dpar     = ^s.in_data;
    cnt_next = (state_q == IDLE) ? CW'(1) : beat_cnt_q + CW'(1);
    trunc    = (cnt_next == MAX_CNT) && !s.in_last;
    last     = s.in_last || trunc;
    err_now  = s.chk_en && ((dpar ^ s.in_par) != odd_eff);

    if (accept) begin
      odd_f_d       = odd_eff;
      out_valid_d   = 1'b1;
      out_data_d    = s.in_data;
      out_par_d     = dpar ^ odd_eff;
      out_last_d    = last;
      frame_par_d   = last ? (acc_q ^ dpar ^ odd_eff) : 1'b0;
      par_err_d     = err_now;
      frame_trunc_d = trunc;
      if (last) begin
        state_d    = IDLE;
        acc_d      = 1'b0;
        beat_cnt_d = '0;
      end else begin
        state_d    = FRAME;
        acc_d      = acc_q ^ dpar;
        beat_cnt_d = cnt_next;
      end
    end else if (s.out_ready) begin
      out_valid_d = 1'b0;
    end

    if (s.err_clr) begin
      err_cnt_d = (accept && err_now) ? CNT_W'(1) : '0;
    end else if (accept && err_now && (err_cnt_q != ERR_MAX)) begin
      err_cnt_d = err_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      beat_cnt_q    <= '0;
      acc_q         <= 1'b0;
      odd_f_q       <= 1'b0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_par_q     <= 1'b0;
      out_last_q    <= 1'b0;
      frame_par_q   <= 1'b0;
      par_err_q     <= 1'b0;
      frame_trunc_q <= 1'b0;
      err_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      beat_cnt_q    <= beat_cnt_d;
      acc_q         <= acc_d;
      odd_f_q       <= odd_f_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_par_q     <= out_par_d;
      out_last_q    <= out_last_d;
      frame_par_q   <= frame_par_d;
      par_err_q     <= par_err_d;
      frame_trunc_q <= frame_trunc_d;
      err_cnt_q     <= err_cnt_d;
    end
  end

  assign s.in_ready    = in_ready;
  assign s.out_valid   = out_valid_q;
  assign s.out_data    = out_data_q;
  assign s.out_par     = out_par_q;
  assign s.out_last    = out_last_q;
  assign s.frame_par   = frame_par_q;
  assign s.par_err     = par_err_q;
  assign s.frame_trunc = frame_trunc_q;
  assign s.err_cnt     = err_cnt_q;
endmodule

// File: tb/tb_parity_gen_stream.sv
// Directed bench for parity_gen_stream (DATA_W=8, MAX_BEATS=4, CNT_W=2).
module tb_parity_gen_stream;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  parity_gen_stream_if #(.DATA_W(8), .CNT_W(2)) bus ();

  parity_gen_stream #(.DATA_W(8), .MAX_BEATS(4), .CNT_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .s     (bus)
  );

  typedef struct {
    logic [7:0] data;
    logic       last;
    logic       par;
    logic       odd;
    logic       chk;
    logic       clr;
    logic       e_par;
    logic       e_fpar;
    logic       e_last;
    logic       e_trunc;
    logic       e_err;
    logic [1:0] e_cnt;
  } vec_t;

  vec_t vecs[25];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic idle_inputs();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    bus.in_last  = 1'b0;
    bus.in_par   = 1'b0;
    bus.odd_sel  = 1'b0;
    bus.chk_en   = 1'b0;
    bus.err_clr  = 1'b0;
  endtask

  // Present one beat for one edge with out_ready=1, then sample 1 time unit later.
  task automatic send(input logic [7:0] d, input logic l, input logic p, input logic o,
                      input logic c, input logic clr);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = l;
    bus.in_par   = p;
    bus.odd_sel  = o;
    bus.chk_en   = c;
    bus.err_clr  = clr;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  function automatic vec_t mk(input logic [7:0] d, input logic l, input logic p,
                              input logic o, input logic c, input logic clr,
                              input logic ep, input logic efp, input logic el,
                              input logic et, input logic ee, input logic [1:0] ec);
    vec_t v;
    v.data = d; v.last = l; v.par = p; v.odd = o; v.chk = c; v.clr = clr;
    v.e_par = ep; v.e_fpar = efp; v.e_last = el; v.e_trunc = et; v.e_err = ee; v.e_cnt = ec;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //           data  last par odd chk clr | par fpar last trunc err cnt
    vecs[0]  = mk(8'hB3, 1, 0, 0, 0, 0,   1, 1, 1, 0, 0, 2'd0); // even single beat
    vecs[1]  = mk(8'hB3, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 2'd0); // odd single beat
    vecs[2]  = mk(8'h01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd0);
    vecs[3]  = mk(8'h03, 0, 0, 1, 0, 0,   0, 0, 0, 0, 0, 2'd0); // odd_sel toggled mid-frame
    vecs[4]  = mk(8'h07, 1, 0, 1, 0, 0,   1, 0, 1, 0, 0, 2'd0);
    vecs[5]  = mk(8'h0F, 1, 0, 0, 1, 0,   0, 0, 1, 0, 0, 2'd0); // check ok
    vecs[6]  = mk(8'h0F, 1, 1, 0, 1, 0,   0, 0, 1, 0, 1, 2'd1); // check error
    vecs[7]  = mk(8'h0F, 1, 1, 0, 1, 0,   0, 0, 1, 0, 1, 2'd2);
    vecs[8]  = mk(8'h0F, 1, 1, 0, 1, 0,   0, 0, 1, 0, 1, 2'd3);
    vecs[9]  = mk(8'h0F, 1, 1, 0, 1, 0,   0, 0, 1, 0, 1, 2'd3); // saturated
    vecs[10] = mk(8'h0F, 1, 1, 0, 1, 1,   0, 0, 1, 0, 1, 2'd1); // clear + error
    vecs[11] = mk(8'h01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd1); // truncated frame
    vecs[12] = mk(8'h03, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 2'd1);
    vecs[13] = mk(8'h01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd1);
    vecs[14] = mk(8'h01, 0, 0, 0, 0, 0,   1, 1, 1, 1, 0, 2'd1);
    vecs[15] = mk(8'h07, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 2'd1); // fresh frame after trunc
    vecs[16] = mk(8'h01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd1); // last exactly at MAX_BEATS
    vecs[17] = mk(8'h01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd1);
    vecs[18] = mk(8'h01, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2'd1);
    vecs[19] = mk(8'h01, 1, 0, 0, 0, 0,   1, 0, 1, 0, 0, 2'd1);
    vecs[20] = mk(8'hFF, 0, 1, 1, 1, 0,   1, 0, 0, 0, 0, 2'd1); // odd frame, check ok
    vecs[21] = mk(8'h80, 1, 1, 0, 1, 0,   0, 0, 1, 0, 1, 2'd2); // odd latched, error
    vecs[22] = mk(8'h00, 1, 0, 0, 0, 1,   0, 0, 1, 0, 0, 2'd0); // plain clear
    vecs[23] = mk(8'h5A, 1, 1, 0, 0, 0,   0, 0, 1, 0, 0, 2'd0); // chk off ignores in_par
    vecs[24] = mk(8'h5B, 1, 0, 1, 0, 0,   0, 0, 1, 0, 0, 2'd0);

    idle_inputs();
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_err_cnt", bus.err_cnt, 0);
    check("rst_in_ready", bus.in_ready, 1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 25; i++) begin
      send(vecs[i].data, vecs[i].last, vecs[i].par, vecs[i].odd, vecs[i].chk, vecs[i].clr);
      check($sformatf("v%0d_valid", i), bus.out_valid, 1);
      check($sformatf("v%0d_data", i), bus.out_data, vecs[i].data);
      check($sformatf("v%0d_par", i), bus.out_par, vecs[i].e_par);
      check($sformatf("v%0d_fpar", i), bus.frame_par, vecs[i].e_fpar);
      check($sformatf("v%0d_last", i), bus.out_last, vecs[i].e_last);
      check($sformatf("v%0d_trunc", i), bus.frame_trunc, vecs[i].e_trunc);
      check($sformatf("v%0d_err", i), bus.par_err, vecs[i].e_err);
      check($sformatf("v%0d_cnt", i), bus.err_cnt, vecs[i].e_cnt);
    end
    @(posedge clk);
    #1;
    check("drain_valid", bus.out_valid, 0);

    // Backpressure: A accepted, B waits 3 stalled cycles, then A/B/C stream.
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h11;
    bus.in_last   = 1'b1;
    @(posedge clk);
    #1;
    check("bp_a_valid", bus.out_valid, 1);
    check("bp_a_data", bus.out_data, 8'h11);
    bus.in_data = 8'h22;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_stall%0d_rdy", i), bus.in_ready, 0);
      @(posedge clk);
      #1;
      check($sformatf("bp_stall%0d_data", i), bus.out_data, 8'h11);
      check($sformatf("bp_stall%0d_valid", i), bus.out_valid, 1);
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp_release_rdy", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check("bp_b_data", bus.out_data, 8'h22);
    bus.in_data = 8'h44;
    @(posedge clk);
    #1;
    check("bp_c_data", bus.out_data, 8'h44);
    check("bp_c_valid", bus.out_valid, 1);
    idle_inputs();
    @(posedge clk);
    #1;
    check("bp_drain", bus.out_valid, 0);

    // Reset mid-frame with a stalled output beat; acc would be 1 if kept.
    send(8'h01, 0, 0, 0, 0, 0);
    send(8'h00, 0, 0, 0, 0, 0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'h01;
    bus.in_last   = 1'b1;
    rst_n         = 1'b0;
    #1;
    check("mrst_in_ready", bus.in_ready, 1);
    @(posedge clk);
    #1;
    check("mrst_valid", bus.out_valid, 0);
    check("mrst_data", bus.out_data, 0);
    check("mrst_par", bus.out_par, 0);
    check("mrst_flags", {bus.out_last, bus.frame_par, bus.par_err, bus.frame_trunc}, 0);
    check("mrst_cnt", bus.err_cnt, 0);
    idle_inputs();
    bus.out_ready = 1'b1;
    rst_n         = 1'b1;
    send(8'h01, 1, 0, 0, 0, 0);
    check("post_rst_fpar", bus.frame_par, 1);
    check("post_rst_last", bus.out_last, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/parity_gen_stream.md
# parity_gen_stream

Parametrised streaming parity generator/checker for DATA_W-bit words. It sits on a valid/ready stream between a producer and a consumer. For every beat it computes per-beat parity, accumulates a frame parity across multi-beat frames, and in check mode compares a supplied parity bit and counts mismatches. Even/odd parity is selectable at run time per frame, and the block has a one-beat registered output stage.

## Interface
- DATA_W, 8, data word width in bits (≥1)
- MAX_BEATS, 16, maximum beats per frame before forced termination (≥2)
- CNT_W, 8, width of the saturating error counter
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  DATA_W  input word
- in_last  in  1  last beat of frame
- in_par  in  1  received parity bit (used only when chk_en=1)
- odd_sel  in  1  0 = even parity, 1 = odd parity; sampled on the first beat of each frame
- chk_en  in  1  1 = check mode; sampled every accepted beat
- err_clr  in  1  clears err_cnt
- out_valid  out  1  output beat valid
- out_ready  in  1  consumer accepts output beat
- out_data  out  DATA_W  registered copy of in_data
- out_par  out  1  generated parity of this beat
- out_last  out  1  last beat of frame (input last or forced)
- frame_par  out  1  accumulated frame parity; meaningful only when out_last=1
- par_err  out  1  this beat failed the check (check mode only)
- frame_trunc  out  1  frame forced to end at MAX_BEATS
- err_cnt  out  CNT_W  saturating count of par_err beats

## Operation
- Accept: a beat is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (combinational). Output registers load on accept.
- Parity:
  - p = ^in_data ^ odd_f, where odd_f is the frame's latched odd_sel.
  - out_par = p. Data plus out_par has even (odd_f=0) or odd (odd_f=1) ones count.
- Frame accumulator:
  - acc holds the XOR of ^in_data over prior beats of the frame.
  - On the last beat, frame_par = acc ^ ^in_data ^ odd_f.
  - On non-last beats, frame_par = 0.
- State machine (2 states):
  - IDLE: no beat of the current frame accepted yet. An accepted beat latches odd_f from odd_sel and sets beat_cnt=1. The state moves to FRAME unless the beat is last.
  - FRAME: an accepted beat increments beat_cnt. When out_last is produced, acc and beat_cnt clear and the state returns to IDLE. No accept means the state holds.
- Forced termination:
  - If the accepted beat is number MAX_BEATS and in_last=0, then out_last=1, frame_trunc=1 and frame_par is computed normally. The next beat starts a new frame in IDLE.
  - frame_trunc=0 on all other beats.
- Check mode (chk_en=1): par_err = (^in_data ^ in_par) != odd_f. With chk_en=0, par_err=0.
- err_cnt:
  - Increments when an accepted beat produces par_err=1.
  - Saturates at 2^CNT_W−1.
  - err_clr=1 forces 0. err_clr together with an erroring accept gives 1.
- Output register holds contents while out_valid && !out_ready (stable under backpressure).

## Timing
- Latency: 1 cycle from accept to out_valid. Throughput: 1 beat/cycle with out_ready=1.
- out_valid sets on accept and clears when out_ready=1 with no new accept. Accept and drain in the same cycle keep out_valid=1 with the new beat.
- odd_sel changes mid-frame have no effect until the next IDLE accept.
- Reset (rst_n=0 on a clock edge), applied at any point including mid-frame or with out_valid stalled:
  - out_valid=0, out_data=0, out_par=0, out_last=0, frame_par=0, par_err=0, frame_trunc=0, err_cnt=0.
  - Internal: acc=0, beat_cnt=0, odd_f=0, state=IDLE.
  - The partial frame is discarded.
- During reset in_ready = 1 (output empty). Beats presented while rst_n=0 are not accepted.

## Test plan
- Reset then single-beat frame, DATA_W=8, odd_sel=0, in_data=0xB3, in_last=1 → next cycle out_valid=1, out_par=1, frame_par=1, out_last=1. Repeat with odd_sel=1 → out_par=0, frame_par=0.
- Three-beat even frame 0x01, 0x03, 0x07 (last) → out_par 1, 0, 1; frame_par=0 on the third beat only; state back to IDLE. Toggle odd_sel after the first beat → no change in results.
- Check mode, even: in_data=0x0F with in_par=0 → par_err=0. in_data=0x0F with in_par=1 → par_err=1, err_cnt=1. With CNT_W=2, four erroring beats → err_cnt saturates at 3. err_clr together with an error → err_cnt=1.
- MAX_BEATS=4, five beats with in_last never set → beat 4 out_last=1, frame_trunc=1. Beat 5 starts a new frame; its frame_par is independent of beats 1–4.
- Backpressure: out_ready=0 for 3 cycles with continuous in_valid → one beat held stable, in_ready=0, no beat lost or duplicated. Release → 1 beat/cycle streaming.
- Reset asserted mid-frame after 2 beats and while out_valid=1 → all outputs 0 next cycle. A following single-beat frame 0x01 gives frame_par=1 (no stale acc).
